// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults and types for the scoreboarded register file
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int CW_DEF    = 2;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  // Largest number of writes that may be in flight to one register
  localparam int CNT_MAX = (1 << CW_DEF) - 1;

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - decode/writeback bus into the register file
interface reg_file_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);

  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic                wb_en;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                iss_ready;

  modport master (
    output rs_addr, wb_en, wb_addr, wb_data, iss_en, iss_addr,
    input  rs_data, rs_busy, iss_ready
  );

  modport slave (
    input  rs_addr, wb_en, wb_addr, wb_data, iss_en, iss_addr,
    output rs_data, rs_busy, iss_ready
  );

endinterface

// File: rtl/rf_pend_cnt.sv
// rtl/rf_pend_cnt.sv - saturating up/down count of writes in flight to one register
module rf_pend_cnt
  import rf_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] FULL = '1;
  localparam logic [CW-1:0] ONE  = CW'(1);

  // Never count past full and never below zero; a write with nothing
  // pending is untracked and leaves the count alone
  logic up;
  logic down;
  assign up   = inc && (cnt != FULL);
  assign down = dec && (cnt != '0);

  // Simultaneous issue and retire cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (up && !down)
      cnt <= cnt + ONE;
    else if (down && !up)
      cnt <= cnt - ONE;
  end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-port register file with write bypass and pending-write scoreboard
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF,
  parameter int CW    = CW_DEF
) (
  input logic         clk,
  input logic         rst,
  reg_file_sb_if.slave bus
);

  localparam int AW = $clog2(NREGS);
  localparam logic [CW-1:0] CNT_FULL = '1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [XLEN-1:0] regs [NREGS];
  logic [CW-1:0]   cnt  [NREGS];

  // x0 has no counter: it is constant and never has writes in flight
  assign cnt[0] = '0;

  genvar r;
  generate
    for (r = 1; r < NREGS; r++) begin : g_cnt
      rf_pend_cnt #(.CW(CW)) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bus.iss_en && bus.iss_ready && (bus.iss_addr == AW'(r))),
        .dec (bus.wb_en && (bus.wb_addr == AW'(r))),
        .cnt (cnt[r])
      );
    end
  endgenerate

  // Writeback storage; writes to x0 are dropped so it always reads zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (bus.wb_en && (bus.wb_addr != '0)) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  logic [NRD*XLEN-1:0] data_mux;
  logic [NRD-1:0]      busy_mux;
  logic [AW-1:0]       ra;
  logic                wb_hit;

  // Read ports: zero for x0, bypass the writeback in this cycle, else storage.
  // A port is not busy when its last pending write retires right now.
  always_comb begin
    data_mux = '0;
    busy_mux = '0;
    ra       = '0;
    wb_hit   = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra     = bus.rs_addr[i*AW +: AW];
      wb_hit = bus.wb_en && (bus.wb_addr == ra);
      if (ra != '0) begin
        data_mux[i*XLEN +: XLEN] = wb_hit ? bus.wb_data : regs[ra];
        busy_mux[i] = (cnt[ra] != '0) && !(wb_hit && (cnt[ra] == CNT_ONE));
      end
    end
  end

  assign bus.rs_data = data_mux;
  assign bus.rs_busy = busy_mux;

  // Issue readiness looks only at the registered count, never at writeback
  assign bus.iss_ready = (bus.iss_addr == '0) || (cnt[bus.iss_addr] != CNT_FULL);

endmodule
